// File: rtl/sd_init_sequencer.sv
// SD card identification/initialization sequencer: CMD0, CMD8, CMD55/ACMD41 poll, CMD2, CMD3, CMD7.
// Latency: POWERUP_CYCLES idle before CMD0; each command waits for its response; POLL_GAP idle between busy polls.
// Backpressure: cmd_valid and its fields are held stable until cmd_ready; responses are only sampled while waiting.
// Optional: define SD_INIT_WIDE_BUS_EN to append CMD55 + ACMD6 (4-bit bus) after CMD7 and add the bus_4bit output.
module sd_init_sequencer #(
    parameter int POWERUP_CYCLES   = 8192,
    parameter int POLL_GAP         = 16384,
    parameter int ACMD41_MAX_TRIES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic [1:0]  cmd_resp_type,
    input  logic        resp_valid,
    input  logic        resp_timeout,
    input  logic        resp_crc_err,
    input  logic [31:0] resp_data,
    output logic        busy,
    output logic        init_done,
    output logic        init_error,
    output logic [2:0]  err_code,
    output logic [15:0] rca,
    output logic        sd_hc,
    output logic        clk_fast
`ifdef SD_INIT_WIDE_BUS_EN
    ,
    output logic        bus_4bit
`endif
);

    localparam int TW   = $clog2(ACMD41_MAX_TRIES + 1);
    localparam int CMAX = (POWERUP_CYCLES > POLL_GAP) ? POWERUP_CYCLES : POLL_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_PWRUP  = 4'd1;
    localparam logic [3:0] S_CMD0   = 4'd2;
    localparam logic [3:0] S_CMD8   = 4'd3;
    localparam logic [3:0] S_CMD55  = 4'd4;
    localparam logic [3:0] S_ACMD41 = 4'd5;
    localparam logic [3:0] S_GAP    = 4'd6;
    localparam logic [3:0] S_CMD2   = 4'd7;
    localparam logic [3:0] S_CMD3   = 4'd8;
    localparam logic [3:0] S_CMD7   = 4'd9;
`ifdef SD_INIT_WIDE_BUS_EN
    localparam logic [3:0] S_CMD55W = 4'd10;
    localparam logic [3:0] S_ACMD6  = 4'd11;
`endif
    localparam logic [3:0] S_DONE   = 4'd12;
    localparam logic [3:0] S_ERROR  = 4'd13;

    logic [3:0]    state;
    logic          waiting;   // handshake done, awaiting response (or one dead cycle for type-0)
    logic [CW-1:0] cnt;       // shared by power-up and poll-gap delays
    logic [TW-1:0] tries;
    logic [TW-1:0] tries_inc;
    logic          v2;        // card answered CMD8 correctly
    logic          is_cmd;
    logic          unused_resp;

    assign tries_inc   = tries + TW'(1);
    assign unused_resp = ^resp_data[15:12];

    // Command fields decoded from the current state; all zero outside command states
    always_comb begin
        is_cmd        = 1'b1;
        cmd_index     = 6'd0;
        cmd_arg       = 32'h0;
        cmd_resp_type = 2'd0;
        case (state)
            S_CMD0:   ;
            S_CMD8:   begin cmd_index = 6'd8;  cmd_arg = 32'h0000_01AA; cmd_resp_type = 2'd1; end
            S_CMD55:  begin cmd_index = 6'd55; cmd_arg = {rca, 16'h0};  cmd_resp_type = 2'd1; end
            S_ACMD41: begin
                cmd_index     = 6'd41;
                cmd_arg       = v2 ? 32'h4030_0000 : 32'h0030_0000;
                cmd_resp_type = 2'd1;
            end
            S_CMD2:   begin cmd_index = 6'd2;  cmd_resp_type = 2'd2; end
            S_CMD3:   begin cmd_index = 6'd3;  cmd_resp_type = 2'd1; end
            S_CMD7:   begin cmd_index = 6'd7;  cmd_arg = {rca, 16'h0};  cmd_resp_type = 2'd1; end
`ifdef SD_INIT_WIDE_BUS_EN
            S_CMD55W: begin cmd_index = 6'd55; cmd_arg = {rca, 16'h0};  cmd_resp_type = 2'd1; end
            S_ACMD6:  begin cmd_index = 6'd6;  cmd_arg = 32'h0000_0002; cmd_resp_type = 2'd1; end
`endif
            default:  is_cmd = 1'b0;
        endcase
        cmd_valid = is_cmd && !waiting;
    end

    // Status outputs follow the state directly so reset clears them immediately
    assign busy       = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
    assign init_done  = (state == S_DONE);
    assign clk_fast   = (state == S_DONE);
    assign init_error = (state == S_ERROR);
`ifdef SD_INIT_WIDE_BUS_EN
    assign bus_4bit   = (state == S_DONE);
`endif

    // Sequence state, delay counters and latched card parameters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            waiting  <= 1'b0;
            cnt      <= '0;
            tries    <= '0;
            v2       <= 1'b0;
            err_code <= 3'd0;
            rca      <= 16'h0;
            sd_hc    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_PWRUP;
                        waiting  <= 1'b0;
                        cnt      <= '0;
                        tries    <= '0;
                        v2       <= 1'b0;
                        err_code <= 3'd0;
                        rca      <= 16'h0;
                        sd_hc    <= 1'b0;
                    end
                end
                S_PWRUP: begin
                    if (cnt == CW'(POWERUP_CYCLES - 1)) begin
                        state   <= S_CMD0;
                        waiting <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == CW'(POLL_GAP - 1)) begin
                        state   <= S_CMD55;
                        waiting <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (!waiting) begin
                        if (cmd_ready) waiting <= 1'b1;
                    end else if (cmd_resp_type == 2'd0) begin
                        // CMD0 has no response: one idle cycle, then CMD8
                        state   <= S_CMD8;
                        waiting <= 1'b0;
                    end else if (resp_timeout) begin
                        waiting <= 1'b0;
                        if (state == S_CMD8) begin
                            // No answer to CMD8 means a v1 card: standard capacity only
                            v2    <= 1'b0;
                            sd_hc <= 1'b0;
                            state <= S_CMD55;
                        end else begin
                            state    <= S_ERROR;
                            err_code <= 3'd5;
                        end
                    end else if (resp_valid) begin
                        waiting <= 1'b0;
                        // R3 (ACMD41) has no meaningful CRC, so its CRC flag is ignored
                        if (resp_crc_err && state != S_ACMD41) begin
                            state    <= S_ERROR;
                            err_code <= 3'd4;
                        end else begin
                            case (state)
                                S_CMD8: begin
                                    if (resp_data[11:0] != 12'h1AA) begin
                                        state    <= S_ERROR;
                                        err_code <= 3'd2;
                                    end else begin
                                        v2    <= 1'b1;
                                        state <= S_CMD55;
                                    end
                                end
                                S_CMD55: state <= S_ACMD41;
                                S_ACMD41: begin
                                    if (resp_data[31]) begin
                                        sd_hc <= v2 & resp_data[30];
                                        state <= S_CMD2;
                                    end else begin
                                        tries <= tries_inc;
                                        if (tries_inc == TW'(ACMD41_MAX_TRIES)) begin
                                            state    <= S_ERROR;
                                            err_code <= 3'd3;
                                        end else begin
                                            state <= S_GAP;
                                            cnt   <= '0;
                                        end
                                    end
                                end
                                S_CMD2: state <= S_CMD3;
                                S_CMD3: begin
                                    rca   <= resp_data[31:16];
                                    state <= S_CMD7;
                                end
`ifdef SD_INIT_WIDE_BUS_EN
                                S_CMD7:   state <= S_CMD55W;
                                S_CMD55W: state <= S_ACMD6;
                                S_ACMD6:  state <= S_DONE;
`else
                                S_CMD7:   state <= S_DONE;
`endif
                                default:  state <= S_ERROR;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer: command tables drive a simple card responder.
// Small delay parameters keep the run short; each table entry is one command/response exchange.
// Hand-written sequences cover power-up latency, backpressure and reset during the poll gap.
module tb_sd_init_sequencer;

    localparam int PWR  = 8;
    localparam int GAPC = 6;
    localparam int MAXT = 3;

    localparam int RK_NONE  = 0;
    localparam int RK_VALID = 1;
    localparam int RK_TO    = 2;
    localparam int RK_BOTH  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0]  cmd_resp_type;
    logic        resp_valid;
    logic        resp_timeout;
    logic        resp_crc_err;
    logic [31:0] resp_data;
    logic        busy;
    logic        init_done;
    logic        init_error;
    logic [2:0]  err_code;
    logic [15:0] rca;
    logic        sd_hc;
    logic        clk_fast;
`ifdef SD_INIT_WIDE_BUS_EN
    logic        bus_4bit;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [1:0]  rtype;
        int          rkind;
        logic        crc;
        logic [31:0] data;
        int          stall;
    } step_t;

    step_t q[$];

    sd_init_sequencer #(
        .POWERUP_CYCLES  (PWR),
        .POLL_GAP        (GAPC),
        .ACMD41_MAX_TRIES(MAXT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .cmd_resp_type(cmd_resp_type),
        .resp_valid   (resp_valid),
        .resp_timeout (resp_timeout),
        .resp_crc_err (resp_crc_err),
        .resp_data    (resp_data),
        .busy         (busy),
        .init_done    (init_done),
        .init_error   (init_error),
        .err_code     (err_code),
        .rca          (rca),
        .sd_hc        (sd_hc),
        .clk_fast     (clk_fast)
`ifdef SD_INIT_WIDE_BUS_EN
        ,
        .bus_4bit     (bus_4bit)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic step_t mk(input logic [5:0] i, input logic [31:0] a, input logic [1:0] t,
                                 input int k, input logic c, input logic [31:0] d, input int st);
        step_t s;
        s.idx = i; s.arg = a; s.rtype = t; s.rkind = k; s.crc = c; s.data = d; s.stall = st;
        return s;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, " cmd outputs"}, {25'h0, cmd_valid, cmd_index, cmd_arg, cmd_resp_type}, 64'h0);
        chk({tag, " status outputs"}, {40'h0, busy, init_done, init_error, err_code, rca, sd_hc, clk_fast}, 64'h0);
`ifdef SD_INIT_WIDE_BUS_EN
        chk({tag, " bus_4bit"}, {63'h0, bus_4bit}, 64'h0);
`endif
    endtask

    // Pulse start, check the clear, and measure cycles until the first cmd_valid
    task automatic do_start(input string tag, output int lat);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy after start"}, {63'h0, busy}, 64'h1);
        chk({tag, " status cleared"}, {42'h0, init_done, init_error, err_code, rca, sd_hc, clk_fast}, 64'h0);
        lat = 0;
        while (!cmd_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_step(input step_t s, input string tag, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!cmd_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: cmd_valid never asserted, expected CMD%0d", tag, s.idx);
            return;
        end
        chk({tag, " index"}, {58'h0, cmd_index}, {58'h0, s.idx});
        chk({tag, " arg"}, {32'h0, cmd_arg}, {32'h0, s.arg});
        chk({tag, " resp_type"}, {62'h0, cmd_resp_type}, {62'h0, s.rtype});
        for (int i = 0; i < s.stall; i++) begin
            @(negedge clk);
            chk({tag, " stalled fields"}, {25'h0, cmd_valid, cmd_index, cmd_arg}, {25'h0, 1'b1, s.idx, s.arg});
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk({tag, " valid drops"}, {63'h0, cmd_valid}, 64'h0);
        if (s.rkind != RK_NONE) begin
            @(negedge clk);
            resp_data    = s.data;
            resp_crc_err = s.crc;
            resp_valid   = (s.rkind == RK_VALID) || (s.rkind == RK_BOTH);
            resp_timeout = (s.rkind == RK_TO) || (s.rkind == RK_BOTH);
            @(negedge clk);
            resp_valid   = 1'b0;
            resp_timeout = 1'b0;
            resp_crc_err = 1'b0;
            resp_data    = 32'h0;
        end
        ok = 1'b1;
    endtask

    task automatic run(input string name);
        bit ok;
        for (int i = 0; i < q.size(); i++) begin
            do_step(q[i], $sformatf("%s#%0d", name, i), ok);
            if (!ok) break;
        end
        @(negedge clk);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cmd_valid) seen++;
        end
        chk({tag, " no further cmd_valid"}, 64'(seen), 64'h0);
    endtask

    initial begin
        int lat;
        reset = 1'b0; start = 1'b0; cmd_ready = 1'b0;
        resp_valid = 1'b0; resp_timeout = 1'b0; resp_crc_err = 1'b0; resp_data = 32'h0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("after reset");

        // v2 SDHC card, two busy polls, checks power-up latency
        do_start("v2", lat);
        chk("v2 powerup latency", 64'(lat), 64'(PWR));
        q = {};
        q.push_back(mk(6'd0,  32'h0,          2'd0, RK_NONE,  1'b0, 32'h0,          0));
        q.push_back(mk(6'd8,  32'h0000_01AA,  2'd1, RK_VALID, 1'b0, 32'h0000_01AA,  0));
        q.push_back(mk(6'd55, 32'h0,          2'd1, RK_VALID, 1'b0, 32'h0000_0120,  0));
        q.push_back(mk(6'd41, 32'h4030_0000,  2'd1, RK_VALID, 1'b0, 32'h00FF_8000,  0));
        q.push_back(mk(6'd55, 32'h0,          2'd1, RK_VALID, 1'b0, 32'h0000_0120,  0));
        q.push_back(mk(6'd41, 32'h4030_0000,  2'd1, RK_VALID, 1'b0, 32'h00FF_8000,  0));
        q.push_back(mk(6'd55, 32'h0,          2'd1, RK_VALID, 1'b0, 32'h0000_0120,  0));
        q.push_back(mk(6'd41, 32'h4030_0000,  2'd1, RK_VALID, 1'b0, 32'hC0FF_8000,  0));
        q.push_back(mk(6'd2,  32'h0,          2'd2, RK_VALID, 1'b0, 32'h0,          0));
        q.push_back(mk(6'd3,  32'h0,          2'd1, RK_VALID, 1'b0, 32'h1234_0500,  0));
        q.push_back(mk(6'd7,  32'h1234_0000,  2'd1, RK_VALID, 1'b0, 32'h0000_0700,  0));
`ifdef SD_INIT_WIDE_BUS_EN
        q.push_back(mk(6'd55, 32'h1234_0000,  2'd1, RK_VALID, 1'b0, 32'h0000_0920,  0));
        q.push_back(mk(6'd6,  32'h0000_0002,  2'd1, RK_VALID, 1'b0, 32'h0000_0920,  0));
`endif
        run("v2");
        chk("v2 done flags", {59'h0, init_done, clk_fast, sd_hc, busy, init_error}, {59'h0, 5'b11100});
        chk("v2 rca", 64'(rca), 64'h1234);
`ifdef SD_INIT_WIDE_BUS_EN
        chk("v2 bus_4bit", {63'h0, bus_4bit}, 64'h1);
`endif

        // v1 card: CMD8 timeout, CRC flag on ACMD41 ignored, CMD2 backpressure
        do_start("v1", lat);
        q = {};
        q.push_back(mk(6'd0,  32'h0,          2'd0, RK_NONE,  1'b0, 32'h0,          0));
        q.push_back(mk(6'd8,  32'h0000_01AA,  2'd1, RK_TO,    1'b0, 32'h0,          0));
        q.push_back(mk(6'd55, 32'h0,          2'd1, RK_VALID, 1'b0, 32'h0000_0120,  0));
        q.push_back(mk(6'd41, 32'h0030_0000,  2'd1, RK_VALID, 1'b1, 32'hC0FF_8000,  0));
        q.push_back(mk(6'd2,  32'h0,          2'd2, RK_VALID, 1'b0, 32'h0,          5));
        q.push_back(mk(6'd3,  32'h0,          2'd1, RK_VALID, 1'b0, 32'h0001_0500,  0));
        q.push_back(mk(6'd7,  32'h0001_0000,  2'd1, RK_VALID, 1'b0, 32'h0000_0700,  0));
`ifdef SD_INIT_WIDE_BUS_EN
        q.push_back(mk(6'd55, 32'h0001_0000,  2'd1, RK_VALID, 1'b0, 32'h0000_0920,  0));
        q.push_back(mk(6'd6,  32'h0000_0002,  2'd1, RK_VALID, 1'b0, 32'h0000_0920,  0));
`endif
        run("v1");
        chk("v1 done", {63'h0, init_done}, 64'h1);
        chk("v1 sd_hc", {63'h0, sd_hc}, 64'h0);
        chk("v1 rca", 64'(rca), 64'h0001);

        // CMD8 echo mismatch
        do_start("mis", lat);
        q = {};
        q.push_back(mk(6'd0,  32'h0,          2'd0, RK_NONE,  1'b0, 32'h0,          0));
        q.push_back(mk(6'd8,  32'h0000_01AA,  2'd1, RK_VALID, 1'b0, 32'h0000_01AB,  0));
        run("mis");
        chk("mis flags", {61'h0, init_error, busy, init_done}, {61'h0, 3'b100});
        chk("mis err_code", 64'(err_code), 64'd2);
        quiet("mis", 20);

        // ACMD41 never ready: exactly MAXT attempts
        do_start("exh", lat);
        q = {};
        q.push_back(mk(6'd0,  32'h0,          2'd0, RK_NONE,  1'b0, 32'h0,          0));
        q.push_back(mk(6'd8,  32'h0000_01AA,  2'd1, RK_VALID, 1'b0, 32'h0000_01AA,  0));
        for (int i = 0; i < MAXT; i++) begin
            q.push_back(mk(6'd55, 32'h0,         2'd1, RK_VALID, 1'b0, 32'h0000_0120, 0));
            q.push_back(mk(6'd41, 32'h4030_0000, 2'd1, RK_VALID, 1'b0, 32'h00FF_8000, 0));
        end
        run("exh");
        chk("exh err_code", 64'(err_code), 64'd3);
        chk("exh init_error", {63'h0, init_error}, 64'h1);
        quiet("exh", 30);

        // CRC error on CMD3
        do_start("crc", lat);
        q = {};
        q.push_back(mk(6'd0,  32'h0,          2'd0, RK_NONE,  1'b0, 32'h0,          0));
        q.push_back(mk(6'd8,  32'h0000_01AA,  2'd1, RK_VALID, 1'b0, 32'h0000_01AA,  0));
        q.push_back(mk(6'd55, 32'h0,          2'd1, RK_VALID, 1'b0, 32'h0000_0120,  0));
        q.push_back(mk(6'd41, 32'h4030_0000,  2'd1, RK_VALID, 1'b0, 32'h80FF_8000,  0));
        q.push_back(mk(6'd2,  32'h0,          2'd2, RK_VALID, 1'b0, 32'h0,          0));
        q.push_back(mk(6'd3,  32'h0,          2'd1, RK_VALID, 1'b1, 32'h5555_0500,  0));
        run("crc");
        chk("crc err_code", 64'(err_code), 64'd4);
        chk("crc flags", {61'h0, init_error, busy, init_done}, {61'h0, 3'b100});

        // Simultaneous valid and timeout on CMD2: timeout wins
        do_start("both", lat);
        q = {};
        q.push_back(mk(6'd0,  32'h0,          2'd0, RK_NONE,  1'b0, 32'h0,          0));
        q.push_back(mk(6'd8,  32'h0000_01AA,  2'd1, RK_VALID, 1'b0, 32'h0000_01AA,  0));
        q.push_back(mk(6'd55, 32'h0,          2'd1, RK_VALID, 1'b0, 32'h0000_0120,  0));
        q.push_back(mk(6'd41, 32'h4030_0000,  2'd1, RK_VALID, 1'b0, 32'h80FF_8000,  0));
        q.push_back(mk(6'd2,  32'h0,          2'd2, RK_BOTH,  1'b0, 32'h0,          0));
        run("both");
        chk("both err_code", 64'(err_code), 64'd5);
        chk("both init_error", {63'h0, init_error}, 64'h1);

        // Reset during the poll gap, then replay from CMD0
        do_start("rg", lat);
        q = {};
        q.push_back(mk(6'd0,  32'h0,          2'd0, RK_NONE,  1'b0, 32'h0,          0));
        q.push_back(mk(6'd8,  32'h0000_01AA,  2'd1, RK_VALID, 1'b0, 32'h0000_01AA,  0));
        q.push_back(mk(6'd55, 32'h0,          2'd1, RK_VALID, 1'b0, 32'h0000_0120,  0));
        q.push_back(mk(6'd41, 32'h4030_0000,  2'd1, RK_VALID, 1'b0, 32'h00FF_8000,  0));
        run("rg");
        chk("rg in gap busy", {62'h0, busy, cmd_valid}, {62'h0, 2'b10});
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rg async reset");
        @(negedge clk);
        reset = 1'b1;
        do_start("rg2", lat);
        chk("rg2 powerup latency", 64'(lat), 64'(PWR));
        q = {};
        q.push_back(mk(6'd0,  32'h0,          2'd0, RK_NONE,  1'b0, 32'h0,          0));
        q.push_back(mk(6'd8,  32'h0000_01AA,  2'd1, RK_VALID, 1'b0, 32'h0000_01AA,  0));
        q.push_back(mk(6'd55, 32'h0,          2'd1, RK_VALID, 1'b0, 32'h0000_0120,  0));
        run("rg2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sd_init_sequencer.md
# sd_init_sequencer

Sequences the SD card identification and initialization command flow on top of `sd_bus_master`'s command channel. It issues CMD0, CMD8, the CMD55/ACMD41 poll loop, CMD2, CMD3 and CMD7 through a valid/ready command interface and checks each response. It then reports the card's RCA and capacity class and switches the bus from identification-speed to transfer-speed clocking. It sits between the top-level playback controller and `sd_bus_master`.

## Interface
- `POWERUP_CYCLES`, 8192: idle cycles after `start` before CMD0 (covers ≥74 SD clocks at init speed).
- `POLL_GAP`, 16384: idle cycles between a busy ACMD41 response and the next CMD55.
- `ACMD41_MAX_TRIES`, 1000: ACMD41 attempts before giving up; counter width is `$clog2(ACMD41_MAX_TRIES+1)`.
- `clk` input 1: system clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins the sequence.
- `cmd_valid` output 1: command request to `sd_bus_master`.
- `cmd_ready` input 1: master accepts the command when high with `cmd_valid`.
- `cmd_index` output 6: command index.
- `cmd_arg` output 32: command argument.
- `cmd_resp_type` output 2: 0 none, 1 short (48-bit), 2 long (136-bit).
- `resp_valid` input 1: one-cycle pulse, response received.
- `resp_timeout` input 1: one-cycle pulse, no response in time.
- `resp_crc_err` input 1: qualifies `resp_valid`.
- `resp_data` input 32: response bits [39:8]; valid with `resp_valid`.
- `busy` output 1: sequence in progress.
- `init_done` output 1: card is in the transfer state.
- `init_error` output 1: sequence failed.
- `err_code` output 3: failure reason, held until the next `start`.
- `rca` output 16: relative card address.
- `sd_hc` output 1: card is SDHC/SDXC (block addressing).
- `clk_fast` output 1: selects the transfer clock divider in the master.

## Operation
- Reset values: all outputs are 0 and the state is IDLE.
- States: IDLE → PWRUP → CMD0 → CMD8 → CMD55 → ACMD41 → (GAP → CMD55 …) → CMD2 → CMD3 → CMD7 → DONE. Any state can go to ERROR.
- Each CMD state has two phases:
  - ISSUE: hold `cmd_valid` with stable fields until `cmd_valid && cmd_ready` on an edge. `cmd_valid` is low on the next cycle.
  - WAIT: wait for `resp_valid` or `resp_timeout`.
  - Response-type-0 commands skip WAIT.
- CMD0: argument 0, type 0.
- CMD8: argument 0x000001AA, type 1.
  - Timeout: v1 card. Set `sd_hc`=0 and use ACMD41 argument 0x00300000.
  - `resp_data[11:0]`≠0x1AA: ERROR, code 2.
  - Otherwise: v2 card, ACMD41 argument 0x40300000.
- CMD55: argument {`rca`,16'h0}, type 1.
- ACMD41: index 41, type 1. CRC error is ignored (R3 carries no valid CRC).
  - `resp_data[31]`=1: set `sd_hc`=`resp_data[30]` (v2 card only), then go to CMD2.
  - `resp_data[31]`=0: increment the try counter. If it equals `ACMD41_MAX_TRIES`, go to ERROR code 3. Otherwise go to GAP, then CMD55.
- CMD2: argument 0, type 2. The response content is ignored.
- CMD3: argument 0, type 1. Latch `rca`=`resp_data[31:16]`.
- CMD7: argument {`rca`,16'h0}, type 1.
- Timeout on any command except CMD8: ERROR, code 5.
- `resp_crc_err` on any command except ACMD41: ERROR, code 4.
- DONE: `clk_fast`=1 and `init_done`=1, held.
- ERROR: `init_error`=1, held.
- `start` handling:
  - In IDLE, DONE or ERROR: clears `init_done`, `init_error`, `err_code`, `rca`, `sd_hc`, `clk_fast` and the try counter, then enters PWRUP.
  - While `busy`: ignored.
- `resp_valid` and `resp_timeout` outside WAIT are ignored.
- `busy`=1 in every state except IDLE, DONE and ERROR.

## Timing
- `start` sampled at edge T → PWRUP from T. `cmd_valid` rises after edge T+`POWERUP_CYCLES`.
- Handshake completes at edge H:
  - Type 0: the next command's `cmd_valid` may assert after H+1.
  - Other types: WAIT from H+1.
- Response pulse at edge R → the next state is entered at R+1. The next `cmd_valid` is visible after R+1.
- GAP lasts exactly `POLL_GAP` cycles.
- Reset asserted mid-sequence clears `cmd_valid` and all outputs immediately (asynchronously).
- If `resp_valid` and `resp_timeout` arrive in the same cycle, timeout wins.

## Configuration
- `SD_INIT_WIDE_BUS_EN` defined: CMD7 is followed by CMD55 then ACMD6 (argument 0x00000002, type 1), then DONE. Adds output `bus_4bit` (reset 0), set to 1 in DONE. ACMD6 errors follow the normal code 4/5 rules.
- `SD_INIT_WIDE_BUS_EN` undefined: CMD7 goes directly to DONE. No `bus_4bit` port.

## Test plan
- v2 SDHC card:
  - Stimulus: CMD8 response 0x000001AA; ACMD41 busy twice, then 0xC0FF8000; CMD3 response 0x12340500.
  - Required: `init_done`=1, `rca`=0x1234, `sd_hc`=1, `clk_fast`=1. CMD55 arguments: 0 during the poll, 0x12340000 after CMD3. Command order: 0, 8, 55, 41, 55, 41, 55, 41, 2, 3, 7.
- v1 card:
  - Stimulus: CMD8 times out.
  - Required: ACMD41 argument is 0x00300000; `sd_hc`=0 even if `resp_data[30]`=1.
- CMD8 mismatch:
  - Stimulus: CMD8 response 0x000001AB.
  - Required: `init_error`=1, `err_code`=2, `busy`=0, no further `cmd_valid`.
- ACMD41 exhaustion:
  - Stimulus: `ACMD41_MAX_TRIES`=3, card always busy.
  - Required: exactly 3 ACMD41 commands, then `err_code`=3.
- Backpressure and reset:
  - Stimulus: `cmd_ready` held low 5 cycles during CMD2.
  - Required: `cmd_index`/`cmd_arg` stable throughout.
  - Stimulus: `reset` asserted during GAP.
  - Required: all outputs 0 at once; a new `start` replays from CMD0.
- CRC error:
  - Stimulus: `resp_crc_err` with the CMD3 response.
  - Required: `err_code`=4.
  - Stimulus: `resp_crc_err` with ACMD41.
  - Required: ignored.
